// File: rtl/kpn_fanout_queue.sv
// Single-writer, multi-reader KPN channel: each token is delivered once to every reader, preloaded with precharge tokens.
// Optional sticky overflow/underflow flags are enabled by defining KPN_QUEUE_ERR_FLAGS_EN.
module kpn_fanout_queue #(
  parameter int BITS_NUMBER              = 16,
  parameter int FIFO_ELEMENTS            = 5,
  parameter int NUMBER_OF_PRECHARGE_DATA = 4,
  parameter int NUM_READERS              = 2,
  parameter int PRECHARGE_BASE           = 0
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            wr,
  input  logic [BITS_NUMBER-1:0]                          data_in,
  output logic                                            full,
  input  logic [NUM_READERS-1:0]                          rd,
  output logic [NUM_READERS*BITS_NUMBER-1:0]              output_1,
  output logic [NUM_READERS-1:0]                          empty,
  output logic [NUM_READERS*$clog2(FIFO_ELEMENTS+1)-1:0]  level
`ifdef KPN_QUEUE_ERR_FLAGS_EN
  ,
  output logic                                            overflow,
  output logic [NUM_READERS-1:0]                          underflow
`endif
);

  localparam int PW = $clog2(FIFO_ELEMENTS);
  localparam int LW = $clog2(FIFO_ELEMENTS + 1);
  localparam logic [PW-1:0] WPTR_RST = PW'(NUMBER_OF_PRECHARGE_DATA % FIFO_ELEMENTS);
  localparam logic [LW-1:0] CNT_RST  = LW'(NUMBER_OF_PRECHARGE_DATA);
  localparam logic [LW-1:0] CNT_MAX  = LW'(FIFO_ELEMENTS);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_ELEMENTS - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [BITS_NUMBER-1:0] precharge_tok(input int i);
    return (i < NUMBER_OF_PRECHARGE_DATA) ? BITS_NUMBER'(PRECHARGE_BASE + i) : '0;
  endfunction

  logic [BITS_NUMBER-1:0] r_mem [FIFO_ELEMENTS];
  logic [PW-1:0]          r_wptr;
  logic [NUM_READERS-1:0] w_at_cap;
  logic                   w_wr_acc;

  // The slowest reader alone decides whether a write is accepted
  assign full     = |w_at_cap;
  assign w_wr_acc = wr & ~full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= WPTR_RST;
      for (int i = 0; i < FIFO_ELEMENTS; i++) r_mem[i] <= precharge_tok(i);
    end else if (w_wr_acc) begin
      r_mem[r_wptr] <= data_in;
      r_wptr        <= ptr_inc(r_wptr);
    end
  end

  for (genvar gi = 0; gi < NUM_READERS; gi++) begin : g_reader
    logic [PW-1:0]          r_rptr;
    logic [PW-1:0]          w_rptr_next;
    logic [LW-1:0]          r_count;
    logic [LW-1:0]          w_count_next;
    logic [BITS_NUMBER-1:0] r_out;
    logic                   w_pop;

    assign w_pop       = rd[gi] && (r_count != '0);
    assign w_rptr_next = w_pop ? ptr_inc(r_rptr) : r_rptr;

    always_comb begin
      w_count_next = r_count;
      if (w_wr_acc && !w_pop)      w_count_next = r_count + 1'b1;
      else if (!w_wr_acc && w_pop) w_count_next = r_count - 1'b1;
    end

    // Show-ahead head register; forward data_in when the new head is the slot being written
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_rptr  <= '0;
        r_count <= CNT_RST;
        r_out   <= precharge_tok(0);
      end else begin
        r_rptr  <= w_rptr_next;
        r_count <= w_count_next;
        if (w_count_next != '0)
          r_out <= (w_wr_acc && (w_rptr_next == r_wptr)) ? data_in : r_mem[w_rptr_next];
      end
    end

    assign w_at_cap[gi]                               = (r_count == CNT_MAX);
    assign empty[gi]                                  = (r_count == '0);
    assign output_1[gi*BITS_NUMBER +: BITS_NUMBER]    = r_out;
    assign level[gi*LW +: LW]                         = r_count;

`ifdef KPN_QUEUE_ERR_FLAGS_EN
    logic r_underflow;
    always_ff @(posedge clk) begin
      if (!rst_n) r_underflow <= 1'b0;
      else        r_underflow <= r_underflow | (rd[gi] & (r_count == '0));
    end
    assign underflow[gi] = r_underflow;
`endif
  end

`ifdef KPN_QUEUE_ERR_FLAGS_EN
  logic r_overflow;
  always_ff @(posedge clk) begin
    if (!rst_n) r_overflow <= 1'b0;
    else        r_overflow <= r_overflow | (wr & full);
  end
  assign overflow = r_overflow;
`endif

endmodule
